axi_traffic_gen: RTL and testbench

Parametrised successor to the bench AXI write master. It drives the ddr2_ctrl AXI slave port with N bursts of write, read-back or write-then-verify traffic. Per-beat data comes from a deterministic pattern. Read data is compared in-line, and mismatches are counted. It sits in the simulation top between the trigger logic and ddr2_ctrl, and is also synthesizable for on-board memory test.

---
 rtl/axi_traffic_gen_pkg.sv | 11 +
 rtl/axi_traffic_gen_if.sv | 14 +
 rtl/axi_traffic_gen_pattern_gen.sv | 14 +
 rtl/axi_traffic_gen.sv | 122 ++++++++++++
 tb/tb_axi_traffic_gen.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_traffic_gen_pkg.sv
// axi_traffic_gen_pkg: shared widths, mode and state encodings for the AXI traffic generator
package axi_traffic_gen_pkg;
   localparam int ROW_BITS = 13;
   localparam int COL_BITS = 10;
   localparam int BA_BITS = 3;
   localparam int DQ_BITS = 16;
   localparam int TG_ADDR_WIDTH = ROW_BITS + COL_BITS + BA_BITS;
   localparam int TG_DATA_WIDTH = 2 * DQ_BITS;
   typedef enum logic [1:0] {MODE_WR = 2'b00, MODE_RD = 2'b01, MODE_WV = 2'b10, MODE_LOOP = 2'b11} mode_t;
   typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;
endpackage

// File: rtl/axi_traffic_gen_if.sv
// axi_traffic_gen_if: AXI write/read channel bundle; master = traffic generator, slave = memory port
interface axi_traffic_gen_if
   import axi_traffic_gen_pkg::*;
#(parameter int ADDR_WIDTH = TG_ADDR_WIDTH, parameter int DATA_WIDTH = TG_DATA_WIDTH);
   logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic arvalid, arready, rvalid, rready, rlast;
   logic [ADDR_WIDTH-1:0] awaddr, araddr;
   logic [7:0] awlen, arlen;
   logic [DATA_WIDTH-1:0] wdata, rdata;
   modport master(output awvalid, awaddr, awlen, wvalid, wlast, wdata, bready, arvalid, araddr, arlen, rready,
                  input awready, wready, bvalid, arready, rvalid, rlast, rdata);
   modport slave(input awvalid, awaddr, awlen, wvalid, wlast, wdata, bready, arvalid, araddr, arlen, rready,
                 output awready, wready, bvalid, arready, rvalid, rlast, rdata);
endinterface

// File: rtl/axi_traffic_gen_pattern_gen.sv
// tg_pattern_gen: combinational expected beat data SEED ^ {k, 8'h00, j}, resized to DATA_WIDTH
//   k: burst index, j: beat index, data: expected beat value
module tg_pattern_gen #(
   parameter int DATA_WIDTH = 32,
   parameter logic [31:0] SEED = 32'hA5A5_0000
) (
   input  logic [15:0] k,
   input  logic [7:0] j,
   output logic [DATA_WIDTH-1:0] data
);
   logic [31:0] raw;
   assign raw = SEED ^ {k, 8'h00, j};
   assign data = DATA_WIDTH'(raw);
endmodule

// File: rtl/axi_traffic_gen.sv
// axi_traffic_gen: N-burst AXI write / read-back / write-then-verify traffic generator
//   clk, rstn (async active-low), trig (rising-edge start), mode, busy, done, err_cnt (saturating)
//   bus: AXI master port; optional err_valid/err_addr/err_data first-mismatch log with TG_ERR_LOG_EN
module axi_traffic_gen
   import axi_traffic_gen_pkg::*;
#(
   parameter int ADDR_WIDTH = TG_ADDR_WIDTH,
   parameter int DATA_WIDTH = TG_DATA_WIDTH,
   parameter logic [7:0] WBURST_LEN = 8'd7,
   parameter logic [7:0] RBURST_LEN = 8'd7,
   parameter int NUM_BURSTS = 4,
   parameter int ADDR_BASE = 0,
   parameter int ADDR_STRIDE = 64,
   parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0000
) (
   input  logic clk,
   input  logic rstn,
   input  logic trig,
   input  logic [1:0] mode,
   output logic busy,
   output logic done,
   output logic [15:0] err_cnt,
`ifdef TG_ERR_LOG_EN
   output logic err_valid,
   output logic [ADDR_WIDTH-1:0] err_addr,
   output logic [DATA_WIDTH-1:0] err_data,
`endif
   axi_traffic_gen_if.master bus
);
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(ADDR_BASE);
   localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);
   state_t state;
   mode_t mode_q;
   logic trig_q, start, last_k, mismatch;
   logic [15:0] k;
   logic [7:0] j;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] exp_data;
   logic [1:0] r_inc;
   logic [16:0] err_sum;
   tg_pattern_gen #(.DATA_WIDTH(DATA_WIDTH), .SEED(PATTERN_SEED)) u_pat (.k(k), .j(j), .data(exp_data));
   assign start = state == IDLE && trig && !trig_q;
   assign last_k = k == 16'(NUM_BURSTS - 1);
   assign mismatch = bus.rdata != exp_data;
   // a data mismatch and a misplaced/missing rlast are counted independently
   assign r_inc = 2'(mismatch) + 2'(bus.rlast != (j == RBURST_LEN));
   assign err_sum = {1'b0, err_cnt} + 17'(r_inc);
   assign busy = state != IDLE && state != DONE;
   assign done = state == DONE;
   assign bus.awvalid = state == AW;
   assign bus.awaddr = bus.awvalid ? addr : '0;
   assign bus.awlen = bus.awvalid ? WBURST_LEN : 8'd0;
   assign bus.wvalid = state == W;
   assign bus.wdata = bus.wvalid ? exp_data : '0;
   assign bus.wlast = bus.wvalid && j == WBURST_LEN;
   assign bus.bready = state == B;
   assign bus.arvalid = state == AR;
   assign bus.araddr = bus.arvalid ? addr : '0;
   assign bus.arlen = bus.arvalid ? RBURST_LEN : 8'd0;
   assign bus.rready = state == R;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state <= IDLE;
         mode_q <= MODE_WR;
         trig_q <= 1'b0;
         k <= '0;
         j <= '0;
         addr <= BASE;
         err_cnt <= '0;
      end else begin
         trig_q <= trig;
         case (state)
            IDLE: if (start) begin
               mode_q <= mode_t'(mode);
               err_cnt <= '0;
               k <= '0;
               j <= '0;
               addr <= BASE;
               state <= mode_t'(mode) == MODE_RD ? AR : AW;
            end
            AW: if (bus.awready) state <= W;
            W: if (bus.wready) begin
               j <= bus.wlast ? 8'd0 : j + 8'd1;
               state <= bus.wlast ? B : W;
            end
            B: if (bus.bvalid) begin
               k <= last_k ? 16'd0 : k + 16'd1;
               addr <= last_k ? BASE : addr + STRIDE;
               state <= !last_k ? AW : mode_q == MODE_WR ? DONE : AR;
            end
            AR: if (bus.arready) state <= R;
            R: if (bus.rvalid) begin
               err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
               j <= bus.rlast ? 8'd0 : j + 8'd1;
               if (bus.rlast) begin
                  k <= last_k ? 16'd0 : k + 16'd1;
                  addr <= last_k ? BASE : addr + STRIDE;
                  // loop mode keeps going only while trig is still held at the end of a pass
                  state <= !last_k ? AR : (mode_q == MODE_LOOP && trig) ? AW : DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
`ifdef TG_ERR_LOG_EN
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         err_valid <= 1'b0;
         err_addr <= '0;
         err_data <= '0;
      end else if (start) begin
         err_valid <= 1'b0;
         err_addr <= '0;
         err_data <= '0;
      end else if (state == R && bus.rvalid && mismatch && !err_valid) begin
         err_valid <= 1'b1;
         err_addr <= addr + ADDR_WIDTH'(j) * ADDR_WIDTH'(DATA_WIDTH / 8);
         err_data <= bus.rdata;
      end
`endif
endmodule

// File: tb/tb_axi_traffic_gen.sv
// tb_axi_traffic_gen: directed self-checking bench acting as the AXI slave for axi_traffic_gen
module tb_axi_traffic_gen;
   logic clk = 1'b0, rstn = 1'b0, trig = 1'b0;
   logic [1:0] mode = 2'b00;
   logic busy, done;
   logic [15:0] err_cnt;
`ifdef TG_ERR_LOG_EN
   logic err_valid;
   logic [25:0] err_addr;
   logic [31:0] err_data;
`endif
   int errors = 0, checks = 0, done_cnt = 0, done_ref;
   axi_traffic_gen_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) bus ();
   axi_traffic_gen dut (
      .clk(clk), .rstn(rstn), .trig(trig), .mode(mode), .busy(busy), .done(done), .err_cnt(err_cnt),
`ifdef TG_ERR_LOG_EN
      .err_valid(err_valid), .err_addr(err_addr), .err_data(err_data),
`endif
      .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   function automatic logic [31:0] expd(input int k, input int j);
      return 32'hA5A5_0000 ^ {k[15:0], 8'h00, j[7:0]};
   endfunction
   function automatic logic sig(input int w);
      case (w)
         0: return bus.awvalid;
         1: return bus.wvalid;
         2: return bus.bready;
         3: return bus.arvalid;
         default: return bus.rready;
      endcase
   endfunction
   task automatic tick;
      @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic wait_sig(input int w, input string tag);
      int n = 0;
      while (!sig(w) && n < 50) begin
         tick;
         n++;
      end
      chk(tag, 64'(sig(w)), 64'd1);
   endtask
   task automatic aw_hs(input int a, input int stall);
      wait_sig(0, "aw_wait");
      chk("awaddr", 64'(bus.awaddr), 64'(a));
      chk("awlen", 64'(bus.awlen), 64'd7);
      repeat (stall ? $urandom_range(0, 2) : 0) begin
         tick;
         chk("aw_hold", 64'({bus.awvalid, bus.awaddr}), 64'({1'b1, 26'(a)}));
      end
      bus.awready = 1'b1;
      tick;
      bus.awready = 1'b0;
   endtask
   task automatic ar_hs(input int a, input int stall);
      wait_sig(3, "ar_wait");
      chk("araddr", 64'(bus.araddr), 64'(a));
      chk("arlen", 64'(bus.arlen), 64'd7);
      repeat (stall ? $urandom_range(0, 2) : 0) begin
         tick;
         chk("ar_hold", 64'({bus.arvalid, bus.araddr}), 64'({1'b1, 26'(a)}));
      end
      bus.arready = 1'b1;
      tick;
      bus.arready = 1'b0;
   endtask
   task automatic w_burst(input int k, input int beats, input int stall);
      for (int j = 0; j < beats; j++) begin
         wait_sig(1, "w_wait");
         chk("wdata", 64'(bus.wdata), 64'(expd(k, j)));
         chk("wlast", 64'(bus.wlast), 64'(j == 7));
         repeat (stall ? $urandom_range(0, 2) : 0) begin
            tick;
            chk("w_hold", 64'({bus.wvalid, bus.wlast, bus.wdata}), 64'({1'b1, j == 7, expd(k, j)}));
         end
         bus.wready = 1'b1;
         tick;
         bus.wready = 1'b0;
      end
   endtask
   task automatic b_resp;
      wait_sig(2, "b_wait");
      bus.bvalid = 1'b1;
      tick;
      bus.bvalid = 1'b0;
   endtask
   task automatic r_burst(input int k, input int flip_j, input int last_j, input int stall);
      for (int j = 0; j <= last_j; j++) begin
         wait_sig(4, "r_wait");
         repeat (stall ? $urandom_range(0, 2) : 0) tick;
         bus.rvalid = 1'b1;
         bus.rdata = expd(k, j) ^ (j == flip_j ? 32'd1 : 32'd0);
         bus.rlast = j == last_j;
         tick;
         bus.rvalid = 1'b0;
         bus.rlast = 1'b0;
         bus.rdata = '0;
      end
   endtask
   task automatic write_pass(input int stall);
      for (int k = 0; k < 4; k++) begin
         aw_hs(k * 64, stall);
         w_burst(k, 8, stall);
         b_resp;
      end
   endtask
   task automatic read_pass(input int stall, input int flip_k, input int flip_j, input int short_k);
      for (int k = 0; k < 4; k++) begin
         ar_hs(k * 64, stall);
         r_burst(k, k == flip_k ? flip_j : -1, k == short_k ? 5 : 7, stall);
      end
   endtask
   task automatic start(input logic [1:0] m, input logic hold);
      mode = m;
      trig = 1'b1;
      tick;
      chk("busy_start", 64'(busy), 64'd1);
      chk("err_clear", 64'(err_cnt), 64'd0);
      if (!hold) trig = 1'b0;
   endtask
   task automatic end_check(input logic [15:0] exp_err);
      chk("done_hi", 64'(done), 64'd1);
      chk("busy_lo", 64'(busy), 64'd0);
      chk("err_cnt", 64'(err_cnt), 64'(exp_err));
      tick;
      chk("done_pulse", 64'(done), 64'd0);
   endtask
   initial begin
      {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast} = '0;
      bus.rdata = '0;
      tick;
      tick;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err_cnt), 64'd0);
      chk("rst_bus", 64'({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, bus.awlen, bus.arlen}), 64'd0);
      rstn = 1'b1;
      tick;
      // write-only, no stalls
      done_ref = done_cnt;
      start(2'b00, 1'b0);
      write_pass(0);
      end_check(16'd0);
      chk("done_once_wr", 64'(done_cnt - done_ref), 64'd1);
      // write-then-verify with random stalls
      done_ref = done_cnt;
      start(2'b10, 1'b0);
      write_pass(1);
      read_pass(1, -1, -1, -1);
      end_check(16'd0);
      chk("done_once_wv", 64'(done_cnt - done_ref), 64'd1);
      // read-only with bit 0 flipped on burst 1 beat 3
      start(2'b01, 1'b0);
      read_pass(0, 1, 3, -1);
      end_check(16'd1);
`ifdef TG_ERR_LOG_EN
      chk("err_valid", 64'(err_valid), 64'd1);
      chk("err_addr", 64'(err_addr), 64'd76);
      chk("err_data", 64'(err_data), 64'(expd(1, 3) ^ 32'd1));
`endif
      // early rlast on beat 5 of burst 0; following bursts still issued
      start(2'b01, 1'b0);
      read_pass(0, -1, -1, 0);
      end_check(16'd1);
      // reset during W beat 4 of burst 2
      start(2'b00, 1'b0);
      for (int k = 0; k < 2; k++) begin
         aw_hs(k * 64, 0);
         w_burst(k, 8, 0);
         b_resp;
      end
      aw_hs(128, 0);
      w_burst(2, 4, 0);
      wait_sig(1, "w4_wait");
      chk("w4_data", 64'(bus.wdata), 64'(expd(2, 4)));
      rstn = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_bus", 64'({bus.awvalid, bus.wvalid, bus.wlast, bus.wdata, bus.bready, bus.arvalid, bus.rready}), 64'd0);
      chk("mid_rst_err", 64'(err_cnt), 64'd0);
      tick;
      rstn = 1'b1;
      tick;
      start(2'b00, 1'b0);
      write_pass(0);
      end_check(16'd0);
      // loop mode: three passes, ignored trig pulse while busy, drop trig in pass 3
      done_ref = done_cnt;
      start(2'b11, 1'b1);
      aw_hs(0, 0);
      trig = 1'b0;
      tick;
      trig = 1'b1;
      w_burst(0, 8, 0);
      b_resp;
      for (int k = 1; k < 4; k++) begin
         aw_hs(k * 64, 0);
         w_burst(k, 8, 0);
         b_resp;
      end
      read_pass(0, -1, -1, -1);
      chk("loop_busy1", 64'(busy), 64'd1);
      write_pass(0);
      read_pass(0, -1, -1, -1);
      chk("loop_busy2", 64'(busy), 64'd1);
      chk("loop_no_done", 64'(done_cnt - done_ref), 64'd0);
      write_pass(0);
      trig = 1'b0;
      read_pass(0, -1, -1, -1);
      end_check(16'd0);
      chk("loop_done_once", 64'(done_cnt - done_ref), 64'd1);
      tick;
      chk("idle_after_loop", 64'({busy, bus.awvalid, bus.arvalid}), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
